// File: rtl/multicycle_controller.sv
// Control FSM for the multicycle MIPS datapath: state sequencing, mux selects, strobes and ALU decode.
// Define MULTICYCLE_BNE_EN to add the bne instruction (BNEEX state).
module multicycle_controller (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       memready,
    output logic       pcen,
    output logic       memwrite,
    output logic       irwrite,
    output logic       regwrite,
    output logic       iord,
    output logic       memtoreg,
    output logic       regdst,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic [2:0] alucontrol,
    output logic [3:0] state
);
    localparam int unsigned STATE_W = 4;

    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;
`ifdef MULTICYCLE_BNE_EN
    localparam logic [5:0] OP_BNE   = 6'b000101;
`endif

    localparam logic [5:0] F_ADD = 6'b100000;
    localparam logic [5:0] F_SUB = 6'b100010;
    localparam logic [5:0] F_AND = 6'b100100;
    localparam logic [5:0] F_OR  = 6'b100101;
    localparam logic [5:0] F_SLT = 6'b101010;

    typedef enum logic [STATE_W-1:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        RTYPEEX = 4'd6,
        RTYPEWB = 4'd7,
        BEQEX   = 4'd8,
        ADDIEX  = 4'd9,
        ADDIWB  = 4'd10,
        JEX     = 4'd11
`ifdef MULTICYCLE_BNE_EN
        ,
        BNEEX   = 4'd12
`endif
    } state_t;

    state_t     state_q;
    state_t     state_d;
    logic       pcwrite;
    logic       branch;
    logic       irwrite_raw;
    logic       memwrite_raw;
    logic       regwrite_raw;
    logic [1:0] aluop;
`ifdef MULTICYCLE_BNE_EN
    logic       bne;
`endif

    // State register; reset aborts any instruction in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and Moore decode of datapath controls.
    always_comb begin
        state_d      = state_q;
        pcwrite      = 1'b0;
        branch       = 1'b0;
        irwrite_raw  = 1'b0;
        memwrite_raw = 1'b0;
        regwrite_raw = 1'b0;
        iord         = 1'b0;
        memtoreg     = 1'b0;
        regdst       = 1'b0;
        alusrca      = 1'b0;
        alusrcb      = 2'b00;
        pcsrc        = 2'b00;
        aluop        = 2'b00;
`ifdef MULTICYCLE_BNE_EN
        bne          = 1'b0;
`endif
        case (state_q)
            FETCH: begin
                alusrcb     = 2'b01;
                irwrite_raw = memready;
                pcwrite     = memready;
                if (memready) begin
                    state_d = DECODE;
                end
            end
            DECODE: begin
                alusrcb = 2'b11;
                case (op)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_RTYPE:     state_d = RTYPEEX;
                    OP_BEQ:       state_d = BEQEX;
                    OP_ADDI:      state_d = ADDIEX;
                    OP_J:         state_d = JEX;
`ifdef MULTICYCLE_BNE_EN
                    OP_BNE:       state_d = BNEEX;
`endif
                    default:      state_d = FETCH;
                endcase
            end
            MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                state_d = (op == OP_LW) ? MEMRD : MEMWR;
            end
            MEMRD: begin
                iord = 1'b1;
                if (memready) begin
                    state_d = MEMWB;
                end
            end
            MEMWB: begin
                memtoreg     = 1'b1;
                regwrite_raw = 1'b1;
                state_d      = FETCH;
            end
            MEMWR: begin
                iord         = 1'b1;
                memwrite_raw = 1'b1;
                if (memready) begin
                    state_d = FETCH;
                end
            end
            RTYPEEX: begin
                alusrca = 1'b1;
                aluop   = 2'b10;
                state_d = RTYPEWB;
            end
            RTYPEWB: begin
                regdst       = 1'b1;
                regwrite_raw = 1'b1;
                state_d      = FETCH;
            end
            BEQEX: begin
                alusrca = 1'b1;
                aluop   = 2'b01;
                pcsrc   = 2'b01;
                branch  = 1'b1;
                state_d = FETCH;
            end
            ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                state_d = ADDIWB;
            end
            ADDIWB: begin
                regwrite_raw = 1'b1;
                state_d      = FETCH;
            end
            JEX: begin
                pcsrc   = 2'b10;
                pcwrite = 1'b1;
                state_d = FETCH;
            end
`ifdef MULTICYCLE_BNE_EN
            BNEEX: begin
                alusrca = 1'b1;
                aluop   = 2'b01;
                pcsrc   = 2'b01;
                bne     = 1'b1;
                state_d = FETCH;
            end
`endif
            default: state_d = FETCH;
        endcase
    end

    // ALU operation from aluop, with funct decode for R-type.
    always_comb begin
        alucontrol = 3'b010;
        case (aluop)
            2'b01: alucontrol = 3'b110;
            2'b10: begin
                case (funct)
                    F_ADD:   alucontrol = 3'b010;
                    F_SUB:   alucontrol = 3'b110;
                    F_AND:   alucontrol = 3'b000;
                    F_OR:    alucontrol = 3'b001;
                    F_SLT:   alucontrol = 3'b111;
                    default: alucontrol = 3'b010;
                endcase
            end
            default: alucontrol = 3'b010;
        endcase
    end

    // Write strobes are masked by reset so nothing is written once reset rises.
    assign irwrite  = irwrite_raw & ~reset;
    assign memwrite = memwrite_raw & ~reset;
    assign regwrite = regwrite_raw & ~reset;
`ifdef MULTICYCLE_BNE_EN
    assign pcen     = ~reset & (pcwrite | (branch & zero) | (bne & ~zero));
`else
    assign pcen     = ~reset & (pcwrite | (branch & zero));
`endif
    assign state    = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: directed vector table, reset corner cases,
// and randomized instructions against an instruction-level reference model.
module tb_multicycle_controller;
    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       memready;
    logic       pcen, memwrite, irwrite, regwrite, iord, memtoreg, regdst, alusrca;
    logic [1:0] alusrcb, pcsrc;
    logic [2:0] alucontrol;
    logic [3:0] state;

    multicycle_controller dut (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero), .memready(memready),
        .pcen(pcen), .memwrite(memwrite), .irwrite(irwrite), .regwrite(regwrite),
        .iord(iord), .memtoreg(memtoreg), .regdst(regdst), .alusrca(alusrca),
        .alusrcb(alusrcb), .pcsrc(pcsrc), .alucontrol(alucontrol), .state(state)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Observations gathered over one instruction.
    int         trace[$];
    int         n_pcen, n_ir, n_mw, n_rw, n_mtr, n_rd, n_iord, alu_bad;
    logic [2:0] alu_ex;
    logic [1:0] pcsrc_ex;

    // Run one instruction from its FETCH cycle until the next FETCH, stalling kf cycles in
    // FETCH and km cycles in the memory-wait state; memready is random wherever it is ignored.
    task automatic exec(input logic [5:0] i_op, input logic [5:0] i_funct, input logic i_zero,
                        input int kf, input int km);
        int   n;
        bit   seen;
        int   sf, sm;
        logic [3:0] s;
        trace.delete();
        n_pcen = 0; n_ir = 0; n_mw = 0; n_rw = 0; n_mtr = 0; n_rd = 0; n_iord = 0; alu_bad = 0;
        alu_ex = 3'b010; pcsrc_ex = 2'b00;
        op = i_op; funct = i_funct; zero = i_zero;
        sf = kf; sm = km; seen = 0; n = 0;
        forever begin
            s = state;
            if (s == 4'd0 && seen) break;
            if (n >= 40) begin
                checks++; errors++;
                $display("FAIL exec_timeout: still running after %0d cycles, expected end by 40", n);
                break;
            end
            if (s != 4'd0) seen = 1;
            if (s == 4'd0) begin
                memready = (sf == 0);
                if (sf > 0) sf--;
            end else if (s == 4'd3 || s == 4'd5) begin
                memready = (sm == 0);
                if (sm > 0) sm--;
            end else begin
                memready = 1'($urandom);
            end
            @(negedge clk);
            trace.push_back(int'(state));
            n_pcen += int'(pcen);  n_ir += int'(irwrite); n_mw += int'(memwrite);
            n_rw   += int'(regwrite); n_mtr += int'(memtoreg); n_rd += int'(regdst);
            n_iord += int'(iord);
            if (state == 4'd6 || state == 4'd8 || state == 4'd12) alu_ex = alucontrol;
            else if (alucontrol != 3'b010) alu_bad++;
            if (state == 4'd8 || state == 4'd11 || state == 4'd12) pcsrc_ex = pcsrc;
            n++;
            @(posedge clk); #1;
        end
    endtask

    task automatic check_trace(input string name, input int exp_q[$]);
        check({name, "_len"}, trace.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < trace.size(); i++)
            check($sformatf("%s_state%0d", name, i), trace[i], exp_q[i]);
    endtask

    // ---------------- reference model (instruction level) ----------------
    typedef enum int { I_LW, I_SW, I_R, I_BEQ, I_ADDI, I_J, I_BNE, I_ILL } iclass_t;

    function automatic iclass_t classify(input logic [5:0] o);
        case (o)
            6'b100011: return I_LW;
            6'b101011: return I_SW;
            6'b000000: return I_R;
            6'b000100: return I_BEQ;
            6'b001000: return I_ADDI;
            6'b000010: return I_J;
`ifdef MULTICYCLE_BNE_EN
            6'b000101: return I_BNE;
`endif
            default:   return I_ILL;
        endcase
    endfunction

    function automatic logic [2:0] rtype_alu(input logic [5:0] f);
        case (f)
            6'b100000: return 3'b010;
            6'b100010: return 3'b110;
            6'b100100: return 3'b000;
            6'b100101: return 3'b001;
            6'b101010: return 3'b111;
            default:   return 3'b010;
        endcase
    endfunction

    task automatic model_check(input string name, input logic [5:0] o, input logic [5:0] f,
                               input logic z, input int kf, input int km);
        int      exp_q[$];
        iclass_t c;
        int      taken;
        c = classify(o);
        for (int i = 0; i <= kf; i++) exp_q.push_back(0);
        exp_q.push_back(1);
        case (c)
            I_LW:   begin exp_q.push_back(2); for (int i = 0; i <= km; i++) exp_q.push_back(3); exp_q.push_back(4); end
            I_SW:   begin exp_q.push_back(2); for (int i = 0; i <= km; i++) exp_q.push_back(5); end
            I_R:    begin exp_q.push_back(6); exp_q.push_back(7); end
            I_BEQ:  exp_q.push_back(8);
            I_ADDI: begin exp_q.push_back(9); exp_q.push_back(10); end
            I_J:    exp_q.push_back(11);
            I_BNE:  exp_q.push_back(12);
            default: ;
        endcase
        taken = (c == I_J || (c == I_BEQ && z) || (c == I_BNE && !z)) ? 1 : 0;
        check_trace(name, exp_q);
        check({name, "_pcen"}, n_pcen, 1 + taken);
        check({name, "_irwrite"}, n_ir, 1);
        check({name, "_memwrite"}, n_mw, (c == I_SW) ? km + 1 : 0);
        check({name, "_regwrite"}, n_rw, (c == I_LW || c == I_R || c == I_ADDI) ? 1 : 0);
        check({name, "_memtoreg"}, n_mtr, (c == I_LW) ? 1 : 0);
        check({name, "_regdst"}, n_rd, (c == I_R) ? 1 : 0);
        check({name, "_iord"}, n_iord, (c == I_LW || c == I_SW) ? km + 1 : 0);
        check({name, "_alu_ex"}, int'(alu_ex),
              (c == I_R) ? int'(rtype_alu(f)) : (c == I_BEQ || c == I_BNE) ? 6 : 2);
        check({name, "_pcsrc"}, int'(pcsrc_ex),
              (c == I_J) ? 2 : (c == I_BEQ || c == I_BNE) ? 1 : 0);
        check({name, "_alu_other"}, alu_bad, 0);
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic [5:0]  op;
        logic [5:0]  funct;
        logic        zero;
        int          kf;
        int          km;
        int          len;
        logic [39:0] seq;      // expected states, first in the low nibble
        int          pcen;
        int          rw;
        int          mw;
        logic [2:0]  alu;
        logic [1:0]  pcsrc;
    } vec_t;

    vec_t vecs[$];

    initial begin
        logic [39:0] seqv;
        reset = 1'b1; memready = 1'b1; op = 6'd0; funct = 6'd0; zero = 1'b0;

        // Reset asserted: FETCH values with strobes masked even though memready=1.
        #2;
        check("rst_state", int'(state), 0);
        check("rst_irwrite", int'(irwrite), 0);
        check("rst_pcen", int'(pcen), 0);
        check("rst_memwrite", int'(memwrite), 0);
        check("rst_regwrite", int'(regwrite), 0);
        check("rst_alusrcb", int'(alusrcb), 1);
        check("rst_alucontrol", int'(alucontrol), 2);
        @(posedge clk); #1;
        reset = 1'b0; memready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("idle_state%0d", i), int'(state), 0);
            check($sformatf("idle_pcen%0d", i), int'(pcen), 0);
            check($sformatf("idle_irwrite%0d", i), int'(irwrite), 0);
            @(posedge clk); #1;
        end

        vecs.push_back('{6'b100011, 6'd0,      1'b0, 0, 0, 5, 40'h43210,    1, 1, 0, 3'b010, 2'b00});
        vecs.push_back('{6'b101011, 6'd0,      1'b0, 0, 2, 6, 40'h555210,   1, 0, 3, 3'b010, 2'b00});
        vecs.push_back('{6'b100011, 6'd0,      1'b1, 2, 1, 8, 40'h43321000, 1, 1, 0, 3'b010, 2'b00});
        vecs.push_back('{6'b000000, 6'b101010, 1'b0, 0, 0, 4, 40'h7610,     1, 1, 0, 3'b111, 2'b00});
        vecs.push_back('{6'b000000, 6'b100010, 1'b0, 0, 0, 4, 40'h7610,     1, 1, 0, 3'b110, 2'b00});
        vecs.push_back('{6'b000000, 6'b100100, 1'b1, 0, 0, 4, 40'h7610,     1, 1, 0, 3'b000, 2'b00});
        vecs.push_back('{6'b000000, 6'b100101, 1'b0, 0, 0, 4, 40'h7610,     1, 1, 0, 3'b001, 2'b00});
        vecs.push_back('{6'b000000, 6'b100000, 1'b0, 0, 0, 4, 40'h7610,     1, 1, 0, 3'b010, 2'b00});
        vecs.push_back('{6'b000000, 6'b000111, 1'b0, 0, 0, 4, 40'h7610,     1, 1, 0, 3'b010, 2'b00});
        vecs.push_back('{6'b000100, 6'd0,      1'b1, 0, 0, 3, 40'h810,      2, 0, 0, 3'b110, 2'b01});
        vecs.push_back('{6'b000100, 6'd0,      1'b0, 0, 0, 3, 40'h810,      1, 0, 0, 3'b110, 2'b01});
        vecs.push_back('{6'b001000, 6'd0,      1'b0, 0, 0, 4, 40'hA910,     1, 1, 0, 3'b010, 2'b00});
        vecs.push_back('{6'b000010, 6'd0,      1'b0, 0, 0, 3, 40'hB10,      2, 0, 0, 3'b010, 2'b10});
        vecs.push_back('{6'b111111, 6'd0,      1'b1, 1, 0, 3, 40'h100,      1, 0, 0, 3'b010, 2'b00});
`ifdef MULTICYCLE_BNE_EN
        vecs.push_back('{6'b000101, 6'd0,      1'b0, 0, 0, 3, 40'hC10,      2, 0, 0, 3'b110, 2'b01});
        vecs.push_back('{6'b000101, 6'd0,      1'b1, 0, 0, 3, 40'hC10,      1, 0, 0, 3'b110, 2'b01});
`else
        vecs.push_back('{6'b000101, 6'd0,      1'b0, 0, 0, 2, 40'h10,       1, 0, 0, 3'b010, 2'b00});
        vecs.push_back('{6'b000101, 6'd0,      1'b1, 0, 0, 2, 40'h10,       1, 0, 0, 3'b010, 2'b00});
`endif

        for (int v = 0; v < vecs.size(); v++) begin
            exec(vecs[v].op, vecs[v].funct, vecs[v].zero, vecs[v].kf, vecs[v].km);
            check($sformatf("vec%0d_len", v), trace.size(), vecs[v].len);
            seqv = vecs[v].seq;
            for (int i = 0; i < vecs[v].len && i < trace.size(); i++)
                check($sformatf("vec%0d_state%0d", v, i), trace[i], int'((seqv >> (4 * i)) & 40'hF));
            check($sformatf("vec%0d_pcen", v), n_pcen, vecs[v].pcen);
            check($sformatf("vec%0d_irwrite", v), n_ir, 1);
            check($sformatf("vec%0d_regwrite", v), n_rw, vecs[v].rw);
            check($sformatf("vec%0d_memwrite", v), n_mw, vecs[v].mw);
            check($sformatf("vec%0d_alu", v), int'(alu_ex), int'(vecs[v].alu));
            check($sformatf("vec%0d_pcsrc", v), int'(pcsrc_ex), int'(vecs[v].pcsrc));
        end

        // Randomized instruction stream against the model.
        for (int t = 0; t < 80; t++) begin
            logic [5:0] r_op, r_funct;
            logic       r_zero;
            case ($urandom_range(0, 8))
                0: r_op = 6'b100011;
                1: r_op = 6'b101011;
                2: r_op = 6'b000000;
                3: r_op = 6'b000100;
                4: r_op = 6'b001000;
                5: r_op = 6'b000010;
                6: r_op = 6'b000101;
                7: r_op = 6'b111111;
                default: r_op = 6'($urandom);
            endcase
            case ($urandom_range(0, 6))
                0: r_funct = 6'b100000;
                1: r_funct = 6'b100010;
                2: r_funct = 6'b100100;
                3: r_funct = 6'b100101;
                4: r_funct = 6'b101010;
                default: r_funct = 6'($urandom);
            endcase
            r_zero = 1'($urandom);
            begin
                int kf, km;
                kf = int'($urandom_range(0, 2));
                km = int'($urandom_range(0, 3));
                exec(r_op, r_funct, r_zero, kf, km);
                model_check($sformatf("rnd%0d", t), r_op, r_funct, r_zero, kf, km);
            end
        end

        // Reset in MEMWR while memwrite is high: strobe drops at once and state returns to FETCH.
        op = 6'b101011; memready = 1'b1;
        @(posedge clk); #1;
        memready = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("mw_state", int'(state), 5);
        check("mw_memwrite", int'(memwrite), 1);
        #2 reset = 1'b1;
        #1;
        check("mwrst_memwrite", int'(memwrite), 0);
        check("mwrst_state", int'(state), 0);
        check("mwrst_regwrite", int'(regwrite), 0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("mwrst_after_state", int'(state), 0);
        check("mwrst_after_memwrite", int'(memwrite), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
